// File: rtl/mem_xbar_ws_if.sv
// Core-side and target-side bus bundle for the wait-state data crossbar.
//   slave  : crossbar view (requests/target read data in, responses/strobes out)
//   master : core/target view (the mirror image)
interface mem_xbar_ws_if #(
    parameter int unsigned N_TGT  = 4,
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MASK_W = DATA_W / 8
);
    // core request side
    logic                    i_req;
    logic [ADDR_W-1:0]       i_addr;
    logic [DATA_W-1:0]       i_data;
    logic                    i_wren;
    logic [MASK_W-1:0]       i_mask;
    logic                    o_ack;
    logic [DATA_W-1:0]       o_data;

    // fault reporting
    logic                    o_fault;
    logic [ADDR_W-1:0]       o_fault_addr;
    logic                    i_fault_clr;

    // shared target side
    logic [ADDR_W-1:0]       o_tgt_addr;
    logic [DATA_W-1:0]       o_tgt_data;
    logic [MASK_W-1:0]       o_tgt_mask;
    logic [N_TGT-1:0]        o_tgt_sel;
    logic [N_TGT-1:0]        o_tgt_wren;
    logic [N_TGT*DATA_W-1:0] i_tgt_data;

    modport slave (
        input  i_req, i_addr, i_data, i_wren, i_mask, i_fault_clr, i_tgt_data,
        output o_ack, o_data, o_fault, o_fault_addr,
               o_tgt_addr, o_tgt_data, o_tgt_mask, o_tgt_sel, o_tgt_wren
    );

    modport master (
        output i_req, i_addr, i_data, i_wren, i_mask, i_fault_clr, i_tgt_data,
        input  o_ack, o_data, o_fault, o_fault_addr,
               o_tgt_addr, o_tgt_data, o_tgt_mask, o_tgt_sel, o_tgt_wren
    );
endinterface

// File: rtl/mem_xbar_ws.sv
// Sequential data-side crossbar: decodes a core request against N_TGT address
// windows, inserts per-target wait states, issues a one-cycle target strobe and
// returns a one-cycle ack. Unmapped accesses return ERR_DATA and set a sticky fault.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_xbar_ws_if.slave (core request/response, fault, target bus)
module mem_xbar_ws #(
    parameter int unsigned             N_TGT        = 4,
    parameter int unsigned             ADDR_W       = 30,
    parameter int unsigned             DATA_W       = 32,
    parameter int unsigned             MASK_W       = DATA_W / 8,
    parameter logic [N_TGT*ADDR_W-1:0] REGION_BASE  = '0,
    parameter logic [N_TGT*ADDR_W-1:0] REGION_LIMIT = '1,
    parameter logic [N_TGT*4-1:0]      WAIT_CYC     = '0,
    parameter logic [31:0]             ERR_DATA     = 32'hDEADBEEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_xbar_ws_if.slave  bus
);

    localparam int unsigned IDX_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic                wren_q, wren_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   fault_addr_q, fault_addr_d;
    logic [ADDR_W-1:0]   tgt_addr_q, tgt_addr_d;
    logic [DATA_W-1:0]   tgt_data_q, tgt_data_d;
    logic [MASK_W-1:0]   tgt_mask_q, tgt_mask_d;
    logic [N_TGT-1:0]    tgt_sel_q, tgt_sel_d;
    logic [N_TGT-1:0]    tgt_wren_q, tgt_wren_d;

    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [CNT_W-1:0]    hit_wait;
    logic [DATA_W-1:0]   rd_word;
    logic                acc_go;
    logic [ADDR_W-1:0]   acc_base;

    // Window decode of the live request; descending scan so the lowest index wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_wait = '0;
        for (int k = int'(N_TGT) - 1; k >= 0; k--) begin
            if ((bus.i_addr >= REGION_BASE[k*ADDR_W +: ADDR_W]) &&
                (bus.i_addr <= REGION_LIMIT[k*ADDR_W +: ADDR_W])) begin
                hit      = 1'b1;
                hit_idx  = IDX_W'(k);
                hit_wait = WAIT_CYC[k*CNT_W +: CNT_W];
            end
        end
    end

    // Read data of the latched target.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < int'(N_TGT); k++) begin
            if (idx_q == IDX_W'(k)) begin
                rd_word = bus.i_tgt_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        mask_d       = mask_q;
        wren_d       = wren_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_data_d   = tgt_data_q;
        tgt_mask_d   = tgt_mask_q;
        tgt_sel_d    = '0;
        tgt_wren_d   = '0;
        acc_go       = 1'b0;
        acc_base     = '0;

        // A fault raised in this same cycle overrides the clear below.
        if (bus.i_fault_clr) begin
            fault_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req) begin
                    addr_d = bus.i_addr;
                    data_d = bus.i_data;
                    mask_d = bus.i_mask;
                    wren_d = bus.i_wren;
                    idx_d  = hit_idx;
                    if (hit) begin
                        if (hit_wait != '0) begin
                            state_d = ST_WAIT;
                            cnt_d   = hit_wait;
                        end else begin
                            state_d = ST_ACCESS;
                            acc_go  = 1'b1;
                        end
                    end else begin
                        state_d      = ST_RESP;
                        ack_d        = 1'b1;
                        fault_d      = 1'b1;
                        fault_addr_d = bus.i_addr;
                        if (!bus.i_wren) begin
                            rdata_d = ERR_WORD;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                    acc_go  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                ack_d   = 1'b1;
                // Synchronous-read target presents its data during the strobe cycle.
                if (!wren_q) begin
                    rdata_d = rd_word;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobe and shared bus are loaded on the edge that enters ACCESS.
        if (acc_go) begin
            for (int k = 0; k < int'(N_TGT); k++) begin
                if (idx_d == IDX_W'(k)) begin
                    tgt_sel_d[k]  = 1'b1;
                    tgt_wren_d[k] = wren_d;
                    acc_base      = REGION_BASE[k*ADDR_W +: ADDR_W];
                end
            end
            tgt_addr_d = addr_d - acc_base;
            tgt_data_d = data_d;
            tgt_mask_d = mask_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            mask_q       <= '0;
            wren_q       <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            tgt_addr_q   <= '0;
            tgt_data_q   <= '0;
            tgt_mask_q   <= '0;
            tgt_sel_q    <= '0;
            tgt_wren_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            mask_q       <= mask_d;
            wren_q       <= wren_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_data_q   <= tgt_data_d;
            tgt_mask_q   <= tgt_mask_d;
            tgt_sel_q    <= tgt_sel_d;
            tgt_wren_q   <= tgt_wren_d;
        end
    end

    assign bus.o_ack        = ack_q;
    assign bus.o_data       = rdata_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_fault_addr = fault_addr_q;
    assign bus.o_tgt_addr   = tgt_addr_q;
    assign bus.o_tgt_data   = tgt_data_q;
    assign bus.o_tgt_mask   = tgt_mask_q;
    assign bus.o_tgt_sel    = tgt_sel_q;
    assign bus.o_tgt_wren   = tgt_wren_q;

endmodule

// File: tb/tb_mem_xbar_ws.sv
// Testbench for mem_xbar_ws: table of request vectors plus hand-written
// sequences (fault clear, back-to-back, reset mid-request). Expected strobes and
// responses go into scoreboard queues and are popped when the DUT produces them.
module tb_mem_xbar_ws;

    localparam int unsigned N_TGT  = 5;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;

    // T0 0x0-0xFFF w0, T1 0x2000-0x2FFF w1, T2 0x1000-0x1FFF w3,
    // T3 0x2000-0x3FFF w2 (overlaps T1), T4 base>limit (never matches)
    localparam logic [N_TGT*ADDR_W-1:0] BASE  =
        {30'h5000, 30'h2000, 30'h1000, 30'h2000, 30'h0};
    localparam logic [N_TGT*ADDR_W-1:0] LIMIT =
        {30'h4000, 30'h3FFF, 30'h1FFF, 30'h2FFF, 30'hFFF};
    localparam logic [N_TGT*4-1:0] WAITS = {4'd0, 4'd2, 4'd3, 4'd1, 4'd0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_xbar_ws_if #(.N_TGT(N_TGT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_xbar_ws #(
        .N_TGT(N_TGT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
        .REGION_BASE(BASE), .REGION_LIMIT(LIMIT), .WAIT_CYC(WAITS),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N_TGT-1:0]  sel;
        logic [N_TGT-1:0]  wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] mask;
    } strb_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              wren;
        logic [MASK_W-1:0] mask;
        int                idx;    // -1 = decode fault
        logic [ADDR_W-1:0] off;
        int                lat;
        logic [DATA_W-1:0] rdata;
    } vec_t;

    strb_t             strb_q[$];
    logic [DATA_W-1:0] resp_q[$];
    strb_t             mon_e;
    logic [DATA_W-1:0] mon_r;

    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    logic exp_fault = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard consumer: every strobe and every ack must match a queued expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((|bus.o_tgt_sel) || (|bus.o_tgt_wren)) begin
                if (strb_q.size() == 0) begin
                    check("unexpected_strobe", 64'(bus.o_tgt_sel), 64'(0));
                end else begin
                    mon_e = strb_q.pop_front();
                    check("tgt_sel",  64'(bus.o_tgt_sel),  64'(mon_e.sel));
                    check("tgt_wren", 64'(bus.o_tgt_wren), 64'(mon_e.wren));
                    check("tgt_addr", 64'(bus.o_tgt_addr), 64'(mon_e.addr));
                    check("tgt_data", 64'(bus.o_tgt_data), 64'(mon_e.data));
                    check("tgt_mask", 64'(bus.o_tgt_mask), 64'(mon_e.mask));
                end
            end
            if (bus.o_ack) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_ack", 64'(bus.o_ack), 64'(0));
                end else begin
                    mon_r = resp_q.pop_front();
                    check("o_data", 64'(bus.o_data), 64'(mon_r));
                end
            end
        end
    end

    task automatic push_exp(input vec_t v);
        strb_t s;
        if (v.idx >= 0) begin
            s.sel  = N_TGT'(1) << v.idx;
            s.wren = v.wren ? s.sel : '0;
            s.addr = v.off;
            s.data = v.data;
            s.mask = v.mask;
            strb_q.push_back(s);
        end
        resp_q.push_back(v.rdata);
    endtask

    task automatic drive(input vec_t v);
        bus.i_req  = 1'b1;
        bus.i_addr = v.addr;
        bus.i_data = v.data;
        bus.i_wren = v.wren;
        bus.i_mask = v.mask;
    endtask

    // Counts negedges until o_ack is seen; gives up after 40.
    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            bus.i_fault_clr = 1'b0;
        end while (!bus.o_ack && cycles < 40);
    endtask

    task automatic do_req(input vec_t v, input bit clr);
        int cyc;
        push_exp(v);
        @(negedge clk);
        drive(v);
        bus.i_fault_clr = clr;
        wait_ack(cyc);
        bus.i_req = 1'b0;
        check("latency", 64'(cyc), 64'(v.lat));
        if (v.idx < 0) exp_fault = 1'b1;
        else if (clr) exp_fault = 1'b0;
        check("fault_flag", 64'(bus.o_fault), 64'(exp_fault));
        if (v.idx < 0) check("fault_addr", 64'(bus.o_fault_addr), 64'(v.addr));
    endtask

    task automatic check_reset_vals();
        check("rst_ack",      64'(bus.o_ack),        64'(0));
        check("rst_data",     64'(bus.o_data),       64'(0));
        check("rst_fault",    64'(bus.o_fault),      64'(0));
        check("rst_faddr",    64'(bus.o_fault_addr), 64'(0));
        check("rst_tgt_addr", 64'(bus.o_tgt_addr),   64'(0));
        check("rst_tgt_data", 64'(bus.o_tgt_data),   64'(0));
        check("rst_tgt_mask", 64'(bus.o_tgt_mask),   64'(0));
        check("rst_tgt_sel",  64'(bus.o_tgt_sel),    64'(0));
        check("rst_tgt_wren", 64'(bus.o_tgt_wren),   64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        vec_t va, vb, vr;
        int   cyc;

        //             addr           data          wr    mask     idx off          lat rdata
        vecs[0]  = '{30'h5,        32'h0,        1'b0, 4'hF,    0,  30'h5,      2, 32'h12345678};
        vecs[1]  = '{30'h1004,     32'hAABBCCDD, 1'b1, 4'b0100, 2,  30'h4,      5, 32'h12345678};
        vecs[2]  = '{30'h2000,     32'h0,        1'b0, 4'hF,    1,  30'h0,      3, 32'h11111111};
        vecs[3]  = '{30'h3000,     32'h0,        1'b0, 4'hF,    3,  30'h1000,   4, 32'h33333333};
        vecs[4]  = '{30'hFFF,      32'h0,        1'b0, 4'hF,    0,  30'hFFF,    2, 32'h12345678};
        vecs[5]  = '{30'h1000,     32'h0,        1'b0, 4'hF,    2,  30'h0,      5, 32'h22222222};
        vecs[6]  = '{30'h2FFF,     32'h01020304, 1'b1, 4'hF,    1,  30'hFFF,    3, 32'h22222222};
        vecs[7]  = '{30'h4800,     32'h0,        1'b0, 4'hF,    -1, 30'h0,      1, 32'hDEADBEEF};
        vecs[8]  = '{30'h2,        32'h0,        1'b0, 4'hF,    0,  30'h2,      2, 32'h12345678};
        vecs[9]  = '{30'h3FFF0000, 32'h99,       1'b1, 4'hF,    -1, 30'h0,      1, 32'h12345678};
        vecs[10] = '{30'h3FFF0000, 32'h0,        1'b0, 4'hF,    -1, 30'h0,      1, 32'hDEADBEEF};

        rst             = 1'b1;
        bus.i_req       = 1'b0;
        bus.i_addr      = '0;
        bus.i_data      = '0;
        bus.i_wren      = 1'b0;
        bus.i_mask      = '0;
        bus.i_fault_clr = 1'b0;
        bus.i_tgt_data  = {32'h44444444, 32'h33333333, 32'h22222222,
                           32'h11111111, 32'h12345678};

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst    = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i], 1'b0);
        end

        // Fault clear, then fault and clear in the same cycle (set wins).
        @(negedge clk);
        bus.i_fault_clr = 1'b1;
        @(negedge clk);
        bus.i_fault_clr = 1'b0;
        exp_fault = 1'b0;
        check("fault_cleared",   64'(bus.o_fault),      64'(0));
        check("fault_addr_kept", 64'(bus.o_fault_addr), 64'(30'h3FFF0000));
        vr = '{30'h3FFF0004, 32'h0, 1'b0, 4'hF, -1, 30'h0, 1, 32'hDEADBEEF};
        do_req(vr, 1'b1);

        // Back-to-back with i_req held; a pulse and address change during WAIT.
        va = '{30'h1008, 32'h0, 1'b0, 4'hF, 2, 30'h8, 5, 32'h22222222};
        vb = '{30'h6,    32'h0, 1'b0, 4'hF, 0, 30'h6, 3, 32'h12345678};
        push_exp(va);
        push_exp(vb);
        @(negedge clk);
        drive(va);
        @(negedge clk);
        bus.i_req = 1'b0;
        @(negedge clk);
        bus.i_req  = 1'b1;
        bus.i_addr = vb.addr;
        wait_ack(cyc);
        check("b2b_lat_first", 64'(cyc), 64'(3));
        wait_ack(cyc);
        check("b2b_lat_second", 64'(cyc), 64'(3));
        bus.i_req = 1'b0;

        // Reset during WAIT of a write: no strobe, no ack, then a clean request.
        vr = '{30'h1010, 32'h55, 1'b1, 4'hF, 2, 30'h10, 5, 32'h0};
        @(negedge clk);
        drive(vr);
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        bus.i_req = 1'b0;
        @(negedge clk);
        check_reset_vals();
        rst       = 1'b0;
        exp_fault = 1'b0;
        repeat (6) @(negedge clk);
        do_req(vecs[0], 1'b0);

        repeat (3) @(negedge clk);
        check("strobe_queue_empty", 64'(strb_q.size()), 64'(0));
        check("resp_queue_empty",   64'(resp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
